// File: rtl/spi_xfer_seq.sv
// SPI mode-0 master transfer sequencer: one DATA_W-bit MSB-first full-duplex
// transfer per accepted start, timed by a half-period divider and a bit counter.
module spi_xfer_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [DIV_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt;
  logic [DATA_W-1:0]   r_tx, w_tx_nxt;
  logic [DATA_W-1:0]   r_rx, w_rx_nxt;
  logic [DATA_W-1:0]   r_rx_data, w_rx_data_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic                r_cs_n, w_cs_n_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                w_tc;

  assign w_tc = (r_cnt == '0);

  // State, counters, shift registers and all outputs are registered here
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; every non-idle phase ends on divider tc
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_cnt_nxt     = (r_state == S_IDLE) ? r_cnt
                  : (w_tc ? r_div : r_cnt - DIV_W'(1));
    w_bit_nxt     = r_bit;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = r_rx_data;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_cs_n_nxt    = r_cs_n;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETUP;
          w_div_nxt   = div;
          w_cnt_nxt   = div;
          w_bit_nxt   = BIT_W'(DATA_W - 1);
          w_tx_nxt    = tx_data;
          w_sclk_nxt  = 1'b0;
          w_mosi_nxt  = tx_data[DATA_W-1];
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SETUP, S_LOW: begin
        if (w_tc) begin
          w_state_nxt = S_HIGH;
          w_sclk_nxt  = 1'b1;
          w_rx_nxt    = {r_rx[DATA_W-2:0], miso};
        end
      end
      S_HIGH: begin
        if (w_tc) begin
          w_sclk_nxt = 1'b0;
          if (r_bit != '0) begin
            w_state_nxt = S_LOW;
            w_bit_nxt   = r_bit - BIT_W'(1);
            w_tx_nxt    = {r_tx[DATA_W-2:0], 1'b0};
            w_mosi_nxt  = r_tx[DATA_W-2];
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_tc) begin
          w_state_nxt   = S_IDLE;
          w_cs_n_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx;
          w_mosi_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs_n    = r_cs_n;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq: loopback, constant and slave-model miso,
// back-to-back start on the done cycle, and asynchronous reset mid-transfer.
module tb_spi_xfer_seq;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic [7:0] div;
  logic [7:0] tx_data;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  spi_xfer_seq #(.DATA_W(8), .DIV_W(8)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .div     (div),
    .tx_data (tx_data),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         cs_low, rises, dones, hi_run, cur_hi, t_fall, t_rise1;
  int         mode;      // 0: loopback, 1: constant one, 2: slave model
  logic [7:0] mosi_smp;
  logic [7:0] slv;
  logic [7:0] rx_at_done;
  logic       busy_at_done;
  logic       p_sclk, p_cs_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cs_low   = 0;
    rises    = 0;
    dones    = 0;
    hi_run   = -1;
    t_fall   = -1;
    t_rise1  = -1;
    mosi_smp = 8'h00;
  endtask

  // One clock cycle: observe outputs on the falling edge, then refresh miso
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!cs_n) cs_low++;
    if (p_cs_n && !cs_n) begin
      t_fall = cyc;
      hi_run = cur_hi;
    end
    cur_hi = cs_n ? cur_hi + 1 : 0;
    if (!p_sclk && sclk) begin
      rises++;
      mosi_smp = {mosi_smp[6:0], mosi};
      if (rises == 1) t_rise1 = cyc;
    end
    if (p_sclk && !sclk) slv = {slv[6:0], 1'b0};
    if (done) begin
      dones++;
      busy_at_done = busy;
      rx_at_done   = rx_data;
    end
    p_sclk = sclk;
    p_cs_n = cs_n;
    case (mode)
      0:       miso = mosi;
      1:       miso = 1'b1;
      default: miso = slv[7];
    endcase
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (dones == 0 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(dones != 0), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sclk"}, 32'(sclk), 32'd0);
    chk({tag, "_mosi"}, 32'(mosi), 32'd0);
    chk({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rx"},   32'(rx_data), 32'd0);
  endtask

  initial begin
    clr_n   = 1'b1;
    start   = 1'b0;
    div     = 8'd0;
    tx_data = 8'h00;
    miso    = 1'b0;
    mode    = 0;
    slv     = 8'h00;
    p_sclk  = 1'b0;
    p_cs_n  = 1'b1;
    cur_hi  = 0;
    busy_at_done = 1'b1;
    rx_at_done   = 8'h00;
    clear_mon();

    // 1: asynchronous reset between clock edges
    #2 clr_n = 1'b0;
    #1 chk_reset_vals("rst_async");
    tick();
    tick();
    clr_n = 1'b1;
    tick();

    // 2: div=0, loopback 0xA5
    mode = 0; div = 8'd0; tx_data = 8'hA5;
    clear_mon();
    pulse_start();
    wait_done("t2_timeout");
    chk("t2_cs_low",     32'(cs_low), 32'd17);
    chk("t2_rises",      32'(rises), 32'd8);
    chk("t2_dones",      32'(dones), 32'd1);
    chk("t2_rx",         32'(rx_at_done), 32'hA5);
    chk("t2_busy_done",  32'(busy_at_done), 32'd0);
    tick();
    chk("t2_done_pulse", 32'(done), 32'd0);

    // 3: div=3, miso held high, 0x3C
    tick();
    mode = 1; miso = 1'b1; div = 8'd3; tx_data = 8'h3C;
    clear_mon();
    pulse_start();
    wait_done("t3_timeout");
    chk("t3_cs_low",  32'(cs_low), 32'd68);
    chk("t3_rises",   32'(rises), 32'd8);
    chk("t3_mosi",    32'(mosi_smp), 32'h3C);
    chk("t3_rx",      32'(rx_at_done), 32'hFF);

    // 4: slave model returns 0x96, div=1
    tick();
    mode = 2; slv = 8'h96; miso = slv[7]; div = 8'd1; tx_data = 8'h00;
    clear_mon();
    pulse_start();
    wait_done("t4_timeout");
    chk("t4_rx",        32'(rx_at_done), 32'h96);
    chk("t4_first_rise", 32'(t_rise1 - t_fall), 32'd2);
    chk("t4_cs_low",    32'(cs_low), 32'd34);

    // 5: starts while busy are ignored; start on done cycle is accepted
    tick();
    mode = 0; div = 8'd1; tx_data = 8'h5A;
    clear_mon();
    pulse_start();
    repeat (3) tick();
    tx_data = 8'hFF; div = 8'd5;
    pulse_start();
    repeat (4) tick();
    pulse_start();
    wait_done("t5a_timeout");
    chk("t5a_rx",     32'(rx_at_done), 32'h5A);
    chk("t5a_cs_low", 32'(cs_low), 32'd34);
    chk("t5a_dones",  32'(dones), 32'd1);
    tx_data = 8'h0F; div = 8'd1;
    clear_mon();
    pulse_start();
    wait_done("t5b_timeout");
    chk("t5b_cs_high", 32'(hi_run), 32'd1);
    chk("t5b_rx",      32'(rx_at_done), 32'h0F);
    chk("t5b_cs_low",  32'(cs_low), 32'd34);

    // 6: reset after the third sclk rise aborts without a done pulse
    tick();
    mode = 0; div = 8'd2; tx_data = 8'h3C;
    clear_mon();
    pulse_start();
    begin
      int n;
      n = 0;
      while (rises < 3 && n < 500) begin
        tick();
        n++;
      end
      chk("t6_third_rise", 32'(rises), 32'd3);
    end
    #2 clr_n = 1'b0;
    #1 chk_reset_vals("t6_rst");
    tick();
    clr_n = 1'b1;
    clear_mon();
    repeat (20) tick();
    chk("t6_no_done", 32'(dones), 32'd0);
    tx_data = 8'h81;
    clear_mon();
    pulse_start();
    wait_done("t6_timeout");
    chk("t6_rx",     32'(rx_at_done), 32'h81);
    chk("t6_cs_low", 32'(cs_low), 32'd51);
    chk("t6_dones",  32'(dones), 32'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
